// File: rtl/demux_out_fifo_if.sv
// Lane-side handshake for one demux output buffer: write/read requests, read data and status.
interface demux_out_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data_in, push, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  data_in, push, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/demux_out_fifo.sv
// Per-lane FIFO behind the 1:2 demux: registered read data, occupancy flags,
// sticky overflow/underflow for the next stage.
module demux_out_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int ADDR_WIDTH   = 2,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input logic             clk,
  input logic             reset,
  demux_out_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  is_full;
  logic                  is_empty;
  logic                  push_acc;
  logic                  pop_acc;

  assign is_full  = (cnt == DEPTH_C);
  assign is_empty = (cnt == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  assign pop_acc  = bus.pop && !is_empty;
  assign push_acc = bus.push && (!is_full || pop_acc);

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= pop_acc;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bus.push && !push_acc) ovf_q <= 1'b1;
      if (bus.pop && is_empty)   unf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_out_fifo.sv
// Directed bench for demux_out_fifo: fill/drain, overflow, underflow, wrap, full push+pop, async reset.
module tb_demux_out_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  demux_out_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  demux_out_fifo #(
    .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .ALMOST_FULL(3), .ALMOST_EMPTY(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock with the given requests; outputs are sampled 1 time unit after the edge.
  task automatic tick(input logic p, input logic q, input logic [7:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"}, 32'(bus.count), 0);
    chk({tag, " empty"}, 32'(bus.empty), 1);
    chk({tag, " almost_empty"}, 32'(bus.almost_empty), 1);
    chk({tag, " full"}, 32'(bus.full), 0);
    chk({tag, " almost_full"}, 32'(bus.almost_full), 0);
    chk({tag, " valid_out"}, 32'(bus.valid_out), 0);
    chk({tag, " data_out"}, 32'(bus.data_out), 0);
    chk({tag, " overflow"}, 32'(bus.overflow), 0);
    chk({tag, " underflow"}, 32'(bus.underflow), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_q [$];
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state("por");

    // fill A1..A4
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b0, 8'hA0 + 8'(i));
      chk($sformatf("fill%0d count", i), 32'(bus.count), 32'(i));
      chk($sformatf("fill%0d almost_full", i), 32'(bus.almost_full), 32'(i >= 3));
      chk($sformatf("fill%0d full", i), 32'(bus.full), 32'(i == 4));
      chk($sformatf("fill%0d almost_empty", i), 32'(bus.almost_empty), 32'(i <= 1));
    end

    // overflow: FF dropped
    tick(1'b1, 1'b0, 8'hFF);
    chk("ovf flag", 32'(bus.overflow), 1);
    chk("ovf count", 32'(bus.count), 4);

    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d valid", i), 32'(bus.valid_out), 1);
      chk($sformatf("drain%0d data", i), 32'(bus.data_out), 32'(8'hA0 + 8'(i)));
      chk($sformatf("drain%0d count", i), 32'(bus.count), 32'(4 - i));
    end
    tick(1'b0, 1'b0, 8'h00);
    chk("idle valid", 32'(bus.valid_out), 0);
    chk("idle data hold", 32'(bus.data_out), 32'h A4);
    chk("idle empty", 32'(bus.empty), 1);

    // underflow
    chk("pre unf", 32'(bus.underflow), 0);
    tick(1'b0, 1'b1, 8'h00);
    chk("unf flag", 32'(bus.underflow), 1);
    chk("unf valid", 32'(bus.valid_out), 0);
    chk("unf data hold", 32'(bus.data_out), 32'hA4);
    tick(1'b1, 1'b1, 8'h10);
    chk("empty pushpop count", 32'(bus.count), 1);
    chk("empty pushpop valid", 32'(bus.valid_out), 0);
    chk("empty pushpop unf", 32'(bus.underflow), 1);
    tick(1'b0, 1'b1, 8'h00);
    chk("empty pushpop data", 32'(bus.data_out), 32'h10);
    chk("empty pushpop valid2", 32'(bus.valid_out), 1);

    // simultaneous push+pop at count 2, crossing pointer wrap
    tick(1'b1, 1'b0, 8'h20);
    tick(1'b1, 1'b0, 8'h21);
    exp_q = '{8'h20, 8'h21};
    for (int i = 0; i < 6; i++) begin
      logic [7:0] e;
      tick(1'b1, 1'b1, 8'h22 + 8'(i));
      exp_q.push_back(8'h22 + 8'(i));
      e = exp_q.pop_front();
      chk($sformatf("sim%0d data", i), 32'(bus.data_out), 32'(e));
      chk($sformatf("sim%0d valid", i), 32'(bus.valid_out), 1);
      chk($sformatf("sim%0d count", i), 32'(bus.count), 2);
    end
    tick(1'b0, 1'b1, 8'h00);
    chk("sim tail0", 32'(bus.data_out), 32'h26);
    chk("sim tail0 count", 32'(bus.count), 1);

    // async reset mid-stream, asserted between edges with data_out/valid_out nonzero
    tick(1'b1, 1'b1, 8'h28);
    chk("pre-rst valid", 32'(bus.valid_out), 1);
    chk("pre-rst data", 32'(bus.data_out), 32'h27);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1'b0, 1'b1, 8'h00);
    chk("post-rst no pop valid", 32'(bus.valid_out), 0);
    chk("post-rst no pop count", 32'(bus.count), 0);
    chk("post-rst unf", 32'(bus.underflow), 1);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // full push+pop
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'h30 + 8'(i));
    chk("full2 full", 32'(bus.full), 1);
    tick(1'b1, 1'b1, 8'h55);
    chk("fullpp data", 32'(bus.data_out), 32'h30);
    chk("fullpp valid", 32'(bus.valid_out), 1);
    chk("fullpp count", 32'(bus.count), 4);
    chk("fullpp overflow", 32'(bus.overflow), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      chk($sformatf("fullpp drain%0d", i), 32'(bus.data_out),
          (i == 3) ? 32'h55 : 32'(8'h31 + 8'(i)));
    end
    chk("final empty", 32'(bus.empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
